// File: rtl/id_pkg.sv
// id_pkg
//   Shared decode constants for the ID stage: MIPS opcode / funct codes,
//   ALU control encodings and the packed control bundle carried into ID/EX.
package id_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_wr_en;
    logic       alu_src;
    logic       reg_wr_en;
    logic [2:0] alu_ctrl;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/reg_file_wt.sv
// reg_file_wt
//   NREGS x XLEN register file, two combinational read ports, one write port.
//   Synchronous active-low reset clears every entry (a write in the reset
//   cycle is dropped). Register 0 reads as zero. A read of the address being
//   written this cycle returns the write data (write-through).
// Ports
//   i_clk, i_reset_n            clock, synchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data write port
//   i_rd_addr1/2, o_rd_data1/2  read ports
module reg_file_wt
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_wr_en,
  input  logic [AW-1:0]   i_wr_addr,
  input  logic [XLEN-1:0] i_wr_data,
  input  logic [AW-1:0]   i_rd_addr1,
  input  logic [AW-1:0]   i_rd_addr2,
  output logic [XLEN-1:0] o_rd_data1,
  output logic [XLEN-1:0] o_rd_data2
);

  logic [NREGS-1:0][XLEN-1:0] r_regs;
  logic                       w_wt1, w_wt2;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      r_regs <= '0;
    else if (i_wr_en && (i_wr_addr != '0))
      r_regs[i_wr_addr] <= i_wr_data;
  end

  assign w_wt1 = i_wr_en && (i_wr_addr == i_rd_addr1);
  assign w_wt2 = i_wr_en && (i_wr_addr == i_rd_addr2);

  assign o_rd_data1 = (i_rd_addr1 == '0) ? '0 : w_wt1 ? i_wr_data : r_regs[i_rd_addr1];
  assign o_rd_data2 = (i_rd_addr2 == '0) ? '0 : w_wt2 ? i_wr_data : r_regs[i_rd_addr2];

endmodule

// File: rtl/id_stage_hazard.sv
// id_stage_hazard
//   MIPS decode stage: decodes IF/ID, reads the register file (WB
//   write-through), forwards MEM-stage ALU results, resolves beq/j in ID,
//   detects load-use / branch-operand hazards and drives the ID/EX register
//   (hold, flush, bubble).
// Optional feature: define DECODE_BNE_EN to decode bne (opcode 000101) as a
//   branch taken on inequality; otherwise it decodes as a NOP.
// Ports
//   i_clk, i_reset_n              clock, synchronous active-low reset
//   i_if_id_valid, i_instr,
//   i_pc_plus_4                   IF/ID slot
//   i_wb_wr_*                     register-file write port from WB
//   i_mem_*                       MEM-stage destination and ALU result
//   i_flush_ex, i_ex_hold         ID/EX bubble / freeze requests
//   o_stall_id                    IF and IF/ID must hold
//   o_jump, o_pc_src,
//   o_pc_jump, o_pc_branch        PC redirect controls and targets
//   o_ex_*                        ID/EX pipeline register contents
module id_stage_hazard
  import id_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_if_id_valid,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc_plus_4,
  input  logic            i_wb_wr_en,
  input  logic [AW-1:0]   i_wb_wr_addr,
  input  logic [XLEN-1:0] i_wb_wr_data,
  input  logic            i_mem_reg_wr_en,
  input  logic            i_mem_mem_to_reg,
  input  logic [AW-1:0]   i_mem_wr_addr,
  input  logic [XLEN-1:0] i_mem_fwd_data,
  input  logic            i_flush_ex,
  input  logic            i_ex_hold,
  output logic            o_stall_id,
  output logic            o_jump,
  output logic            o_pc_src,
  output logic [XLEN-1:0] o_pc_jump,
  output logic [XLEN-1:0] o_pc_branch,
  output logic            o_ex_valid,
  output logic            o_ex_mem_to_reg,
  output logic            o_ex_mem_wr_en,
  output logic            o_ex_alu_src,
  output logic            o_ex_reg_wr_en,
  output logic [2:0]      o_ex_alu_ctrl,
  output logic [AW-1:0]   o_ex_rs,
  output logic [AW-1:0]   o_ex_rt,
  output logic [AW-1:0]   o_ex_wr_addr,
  output logic [XLEN-1:0] o_ex_data1,
  output logic [XLEN-1:0] o_ex_data2,
  output logic [XLEN-1:0] o_ex_imm
);

  // ---------------------------------------------------------------- decode
  logic [5:0]      w_op, w_fn;
  logic [AW-1:0]   w_rs, w_rt, w_rd, w_dst;
  logic [XLEN-1:0] w_imm;
  ctrl_t           w_ctrl;
  logic            w_branch, w_is_bne, w_jmp;

  assign w_op  = i_instr[31:26];
  assign w_fn  = i_instr[5:0];
  assign w_rs  = i_instr[21 +: AW];
  assign w_rt  = i_instr[16 +: AW];
  assign w_rd  = i_instr[11 +: AW];
  assign w_dst = (w_op == OP_RTYPE) ? w_rd : w_rt;
  assign w_imm = {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};

  always_comb begin
    w_ctrl   = CTRL_NOP;
    w_branch = 1'b0;
    w_is_bne = 1'b0;
    w_jmp    = 1'b0;
    case (w_op)
      OP_RTYPE: begin
        w_ctrl.reg_wr_en = 1'b1;
        case (w_fn)
          FN_ADD:  w_ctrl.alu_ctrl = ALU_ADD;
          FN_SUB:  w_ctrl.alu_ctrl = ALU_SUB;
          FN_AND:  w_ctrl.alu_ctrl = ALU_AND;
          FN_OR:   w_ctrl.alu_ctrl = ALU_OR;
          FN_SLT:  w_ctrl.alu_ctrl = ALU_SLT;
          default: w_ctrl.reg_wr_en = 1'b0;   // unknown funct -> NOP
        endcase
      end
      OP_LW: begin
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.reg_wr_en  = 1'b1;
        w_ctrl.alu_ctrl   = ALU_ADD;
      end
      OP_SW: begin
        w_ctrl.mem_wr_en = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.alu_ctrl  = ALU_ADD;
      end
      OP_ADDI: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_wr_en = 1'b1;
        w_ctrl.alu_ctrl  = ALU_ADD;
      end
      // Branches resolve here; SUB is kept in EX to match the classic
      // 5-stage control table.
      OP_BEQ: begin
        w_branch        = 1'b1;
        w_ctrl.alu_ctrl = ALU_SUB;
      end
`ifdef DECODE_BNE_EN
      OP_BNE: begin
        w_branch        = 1'b1;
        w_is_bne        = 1'b1;
        w_ctrl.alu_ctrl = ALU_SUB;
      end
`endif
      OP_J:    w_jmp = 1'b1;
      default: ;
    endcase
    if (!i_if_id_valid) begin
      w_ctrl   = CTRL_NOP;
      w_branch = 1'b0;
      w_is_bne = 1'b0;
      w_jmp    = 1'b0;
    end
  end

  // --------------------------------------------------- register file + fwd
  logic [XLEN-1:0] w_rf1, w_rf2, w_data1, w_data2;
  logic            w_mem_fwd;

  reg_file_wt #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_wr_en    (i_wb_wr_en),
    .i_wr_addr  (i_wb_wr_addr),
    .i_wr_data  (i_wb_wr_data),
    .i_rd_addr1 (w_rs),
    .i_rd_addr2 (w_rt),
    .o_rd_data1 (w_rf1),
    .o_rd_data2 (w_rf2)
  );

  // Only ALU results can be forwarded from MEM; load data is not ready yet.
  assign w_mem_fwd = i_mem_reg_wr_en && !i_mem_mem_to_reg && (i_mem_wr_addr != '0);
  assign w_data1   = (w_mem_fwd && (i_mem_wr_addr == w_rs)) ? i_mem_fwd_data : w_rf1;
  assign w_data2   = (w_mem_fwd && (i_mem_wr_addr == w_rt)) ? i_mem_fwd_data : w_rf2;

  // ---------------------------------------------------------------- hazards
  logic            r_ex_valid;
  ctrl_t           r_ex_ctrl;
  logic [AW-1:0]   r_ex_rs, r_ex_rt, r_ex_wr_addr;
  logic [XLEN-1:0] r_ex_data1, r_ex_data2, r_ex_imm;
  logic            w_hz_lu, w_hz_bex, w_hz_bmem, w_hz, w_taken;

  function automatic logic hit(input logic [AW-1:0] a, rs, rt);
    return (a != '0) && ((a == rs) || (a == rt));
  endfunction

  assign w_hz_lu   = r_ex_valid && r_ex_ctrl.mem_to_reg && hit(r_ex_wr_addr, w_rs, w_rt);
  assign w_hz_bex  = w_branch && r_ex_valid && r_ex_ctrl.reg_wr_en && hit(r_ex_wr_addr, w_rs, w_rt);
  assign w_hz_bmem = w_branch && i_mem_reg_wr_en && i_mem_mem_to_reg && hit(i_mem_wr_addr, w_rs, w_rt);
  assign w_hz      = w_hz_lu || w_hz_bex || w_hz_bmem;

  assign w_taken     = w_is_bne ? (w_data1 != w_data2) : (w_data1 == w_data2);
  assign o_stall_id  = w_hz || i_ex_hold;
  assign o_pc_src    = w_branch && !w_hz && w_taken;
  assign o_jump      = w_jmp && !i_ex_hold;
  assign o_pc_branch = i_pc_plus_4 + (w_imm << 2);
  assign o_pc_jump   = {i_pc_plus_4[XLEN-1:28], i_instr[25:0], 2'b00};

  // ------------------------------------------------------------------ ID/EX
  // Reset and flush beat hold; a hazard bubble only applies when not held.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush_ex || (!i_ex_hold && w_hz)) begin
      r_ex_valid   <= 1'b0;
      r_ex_ctrl    <= CTRL_NOP;
      r_ex_rs      <= '0;
      r_ex_rt      <= '0;
      r_ex_wr_addr <= '0;
      r_ex_data1   <= '0;
      r_ex_data2   <= '0;
      r_ex_imm     <= '0;
    end else if (!i_ex_hold) begin
      r_ex_valid   <= i_if_id_valid;
      r_ex_ctrl    <= w_ctrl;
      r_ex_rs      <= w_rs;
      r_ex_rt      <= w_rt;
      r_ex_wr_addr <= w_dst;
      r_ex_data1   <= w_data1;
      r_ex_data2   <= w_data2;
      r_ex_imm     <= w_imm;
    end
  end

  assign o_ex_valid      = r_ex_valid;
  assign o_ex_mem_to_reg = r_ex_ctrl.mem_to_reg;
  assign o_ex_mem_wr_en  = r_ex_ctrl.mem_wr_en;
  assign o_ex_alu_src    = r_ex_ctrl.alu_src;
  assign o_ex_reg_wr_en  = r_ex_ctrl.reg_wr_en;
  assign o_ex_alu_ctrl   = r_ex_ctrl.alu_ctrl;
  assign o_ex_rs         = r_ex_rs;
  assign o_ex_rt         = r_ex_rt;
  assign o_ex_wr_addr    = r_ex_wr_addr;
  assign o_ex_data1      = r_ex_data1;
  assign o_ex_data2      = r_ex_data2;
  assign o_ex_imm        = r_ex_imm;

endmodule

// File: tb/tb_id_stage_hazard.sv
// tb_id_stage_hazard
//   Directed test-plan scenarios followed by randomized traffic, all checked
//   every cycle against a mnemonic-level reference model of the ID stage.
module tb_id_stage_hazard;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);
`ifdef DECODE_BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, if_id_valid, wb_wr_en, mem_reg_wr_en, mem_mem_to_reg, flush_ex, ex_hold;
  logic [31:0]     instr;
  logic [XLEN-1:0] pc_plus_4, wb_wr_data, mem_fwd_data;
  logic [AW-1:0]   wb_wr_addr, mem_wr_addr;
  logic            stall_id, jump, pc_src;
  logic [XLEN-1:0] pc_jump, pc_branch;
  logic            ex_valid, ex_mem_to_reg, ex_mem_wr_en, ex_alu_src, ex_reg_wr_en;
  logic [2:0]      ex_alu_ctrl;
  logic [AW-1:0]   ex_rs, ex_rt, ex_wr_addr;
  logic [XLEN-1:0] ex_data1, ex_data2, ex_imm;

  id_stage_hazard #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_if_id_valid(if_id_valid), .i_instr(instr),
    .i_pc_plus_4(pc_plus_4), .i_wb_wr_en(wb_wr_en), .i_wb_wr_addr(wb_wr_addr),
    .i_wb_wr_data(wb_wr_data), .i_mem_reg_wr_en(mem_reg_wr_en),
    .i_mem_mem_to_reg(mem_mem_to_reg), .i_mem_wr_addr(mem_wr_addr),
    .i_mem_fwd_data(mem_fwd_data), .i_flush_ex(flush_ex), .i_ex_hold(ex_hold),
    .o_stall_id(stall_id), .o_jump(jump), .o_pc_src(pc_src), .o_pc_jump(pc_jump),
    .o_pc_branch(pc_branch), .o_ex_valid(ex_valid), .o_ex_mem_to_reg(ex_mem_to_reg),
    .o_ex_mem_wr_en(ex_mem_wr_en), .o_ex_alu_src(ex_alu_src), .o_ex_reg_wr_en(ex_reg_wr_en),
    .o_ex_alu_ctrl(ex_alu_ctrl), .o_ex_rs(ex_rs), .o_ex_rt(ex_rt), .o_ex_wr_addr(ex_wr_addr),
    .o_ex_data1(ex_data1), .o_ex_data2(ex_data2), .o_ex_imm(ex_imm)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------------- reference model
  typedef struct {
    logic v, m2r, mw, asrc, rw;
    logic [2:0] alu;
    logic [AW-1:0] rs, rt, wa;
    logic [XLEN-1:0] d1, d2, imm;
  } ex_t;

  logic [XLEN-1:0] m_rf [NREGS];
  ex_t             m_ex;
  logic            s_stall, s_psrc;
  logic [XLEN-1:0] s_pb;

  function automatic string mnem(input logic valid, input logic [31:0] ins);
    if (!valid) return "nop";
    case (ins[31:26])
      6'h00: case (ins[5:0])
               6'h20:   return "add";
               6'h22:   return "sub";
               6'h24:   return "and";
               6'h25:   return "or";
               6'h2a:   return "slt";
               default: return "nop";
             endcase
      6'h23:   return "lw";
      6'h2b:   return "sw";
      6'h08:   return "addi";
      6'h04:   return "beq";
      6'h05:   return BNE_ON ? "bne" : "nop";
      6'h02:   return "j";
      default: return "nop";
    endcase
  endfunction

  function automatic bit hit(input logic [AW-1:0] a, input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    return (a != 0) && ((a == rs) || (a == rt));
  endfunction

  // Operand value seen by ID: MEM ALU result, else WB write-through, else file.
  function automatic logic [XLEN-1:0] opnd(input logic [AW-1:0] a);
    if (mem_reg_wr_en && !mem_mem_to_reg && mem_wr_addr != 0 && mem_wr_addr == a) return mem_fwd_data;
    if (a == 0) return '0;
    if (wb_wr_en && wb_wr_addr == a) return wb_wr_data;
    return m_rf[a];
  endfunction

  task automatic eval(output ex_t nx, output bit hz, output bit stall, output bit jmp,
                      output bit psrc, output logic [XLEN-1:0] pj, output logic [XLEN-1:0] pb);
    string m;
    bit br, taken;
    m  = mnem(if_id_valid, instr);
    br = (m == "beq") || (m == "bne");
    nx.v    = if_id_valid;
    nx.rs   = instr[21 +: AW];
    nx.rt   = instr[16 +: AW];
    nx.wa   = (instr[31:26] == 6'h00) ? instr[11 +: AW] : instr[16 +: AW];
    nx.m2r  = (m == "lw");
    nx.mw   = (m == "sw");
    nx.asrc = (m == "lw") || (m == "sw") || (m == "addi");
    nx.rw   = (m == "add") || (m == "sub") || (m == "and") || (m == "or") ||
              (m == "slt") || (m == "lw") || (m == "addi");
    nx.alu  = (m == "and") ? 3'd0 : (m == "or") ? 3'd1 : (m == "slt") ? 3'd7 :
              ((m == "sub") || br) ? 3'd6 :
              ((m == "add") || (m == "lw") || (m == "sw") || (m == "addi")) ? 3'd2 : 3'd0;
    nx.d1   = opnd(nx.rs);
    nx.d2   = opnd(nx.rt);
    nx.imm  = XLEN'(longint'($signed(instr[15:0])));
    hz = (m_ex.v && m_ex.m2r && hit(m_ex.wa, nx.rs, nx.rt)) ||
         (br && m_ex.v && m_ex.rw && hit(m_ex.wa, nx.rs, nx.rt)) ||
         (br && mem_reg_wr_en && mem_mem_to_reg && hit(mem_wr_addr, nx.rs, nx.rt));
    stall = hz || ex_hold;
    taken = (m == "bne") ? (nx.d1 != nx.d2) : (nx.d1 == nx.d2);
    psrc  = br && !hz && taken;
    jmp   = (m == "j") && !ex_hold;
    pb    = pc_plus_4 + XLEN'(longint'($signed(instr[15:0])) * 4);
    pj    = ((pc_plus_4 >> 28) << 28) | XLEN'({instr[25:0], 2'b00});
  endtask

  // One clock: check combinational outputs mid-cycle, advance the model at
  // the edge, then check the ID/EX register just after it.
  task automatic tick();
    ex_t nx;
    bit hz, stall, jmp, psrc;
    logic [XLEN-1:0] pj, pb;
    @(negedge clk);
    eval(nx, hz, stall, jmp, psrc, pj, pb);
    s_stall = stall_id; s_psrc = pc_src; s_pb = pc_branch;
    chk("stall_id", stall_id, stall);
    chk("jump", jump, jmp);
    chk("pc_src", pc_src, psrc);
    chk("pc_jump", pc_jump, pj);
    chk("pc_branch", pc_branch, pb);
    @(posedge clk);
    if (!reset_n) begin
      m_ex = '{default: '0};
      foreach (m_rf[i]) m_rf[i] = '0;
    end else begin
      if (flush_ex)      m_ex = '{default: '0};
      else if (ex_hold)  m_ex = m_ex;
      else if (hz)       m_ex = '{default: '0};
      else               m_ex = nx;
      if (wb_wr_en && wb_wr_addr != 0) m_rf[wb_wr_addr] = wb_wr_data;
    end
    #1;
    chk("ex_valid", ex_valid, m_ex.v);
    chk("ex_mem_to_reg", ex_mem_to_reg, m_ex.m2r);
    chk("ex_mem_wr_en", ex_mem_wr_en, m_ex.mw);
    chk("ex_alu_src", ex_alu_src, m_ex.asrc);
    chk("ex_reg_wr_en", ex_reg_wr_en, m_ex.rw);
    chk("ex_alu_ctrl", ex_alu_ctrl, m_ex.alu);
    chk("ex_rs", ex_rs, m_ex.rs);
    chk("ex_rt", ex_rt, m_ex.rt);
    chk("ex_wr_addr", ex_wr_addr, m_ex.wa);
    chk("ex_data1", ex_data1, m_ex.d1);
    chk("ex_data2", ex_data2, m_ex.d2);
    chk("ex_imm", ex_imm, m_ex.imm);
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic quiet();
    wb_wr_en = 0; wb_wr_addr = '0; wb_wr_data = '0;
    mem_reg_wr_en = 0; mem_mem_to_reg = 0; mem_wr_addr = '0; mem_fwd_data = '0;
    flush_ex = 0; ex_hold = 0; if_id_valid = 1;
  endtask

  localparam logic [5:0] OPS [8] = '{6'h00, 6'h23, 6'h2b, 6'h08, 6'h04, 6'h05, 6'h02, 6'h3f};
  localparam logic [5:0] FNS [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};

  initial begin
    // Reset with a concurrent WB write to r3 that must be discarded.
    quiet();
    reset_n = 0; if_id_valid = 0; instr = '0; pc_plus_4 = 32'h0000_1000;
    wb_wr_en = 1; wb_wr_addr = 3; wb_wr_data = 32'h55;
    m_ex = '{default: '0};
    foreach (m_rf[i]) m_rf[i] = '0;
    @(posedge clk); #1;
    tick();
    chk("rst_ex_valid", ex_valid, 0);
    quiet(); reset_n = 1;
    instr = rtype(6'h20, 5, 3, 0);
    tick();
    chk("rst_no_stall", s_stall, 0);
    chk("rst_r3_zero", ex_data1, 0);

    // WB write-through, then MEM forwarding on the same operand.
    instr = rtype(6'h20, 5, 4, 0);
    wb_wr_en = 1; wb_wr_addr = 4; wb_wr_data = 32'hA;
    tick();
    chk("wt_data1", ex_data1, 32'hA);
    quiet();
    mem_reg_wr_en = 1; mem_wr_addr = 4; mem_fwd_data = 32'h7;
    tick();
    chk("fwd_data1", ex_data1, 32'h7);
    quiet();

    // Load-use: one stall cycle, one bubble, then the add enters EX.
    instr = itype(6'h23, 1, 2, 0);
    tick();
    instr = rtype(6'h20, 3, 2, 2);
    tick();
    chk("lu_stall", s_stall, 1);
    chk("lu_bubble", ex_valid, 0);
    tick();
    chk("lu_released", s_stall, 0);
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_dst", ex_wr_addr, 3);

    // lw feeding beq: branch-EX stall, branch-MEM stall, then taken.
    instr = itype(6'h23, 1, 2, 0);
    tick();
    instr = itype(6'h04, 2, 0, 3); pc_plus_4 = 32'h0000_0100;
    tick();
    chk("lwbr_stall1", s_stall, 1);
    mem_reg_wr_en = 1; mem_mem_to_reg = 1; mem_wr_addr = 2;
    tick();
    chk("lwbr_stall2", s_stall, 1);
    quiet();
    wb_wr_en = 1; wb_wr_addr = 2; wb_wr_data = '0;
    tick();
    chk("lwbr_nostall", s_stall, 0);
    chk("lwbr_taken", s_psrc, 1);
    chk("lwbr_target", s_pb, 32'h0000_010C);
    quiet();

    // Hold for three cycles, then flush together with hold.
    instr = rtype(6'h20, 6, 1, 1);
    tick();
    ex_hold = 1;
    for (int i = 0; i < 3; i++) begin
      instr = rtype(6'h22, 7, i, 2);
      tick();
      chk("hold_valid", ex_valid, 1);
      chk("hold_dst", ex_wr_addr, 6);
    end
    flush_ex = 1;
    tick();
    chk("flush_stall", s_stall, 1);
    chk("flush_valid", ex_valid, 0);
    quiet();

    // bne r1,r2 with r1=1, r2=2.
    instr = '0;
    wb_wr_en = 1; wb_wr_addr = 1; wb_wr_data = 1;
    tick();
    wb_wr_addr = 2; wb_wr_data = 2;
    tick();
    quiet();
    instr = itype(6'h05, 1, 2, 4);
    tick();
    chk("bne_taken", s_psrc, BNE_ON);

    // Randomized traffic over a small register window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] op, fn;
      reset_n     = ($urandom_range(0, 63) != 0);
      if_id_valid = ($urandom_range(0, 7) != 0);
      op = OPS[$urandom_range(0, 7)];
      fn = FNS[$urandom_range(0, 5)];
      instr = {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), fn};
      if ($urandom_range(0, 3) == 0) instr[15:0] = 16'($urandom);
      pc_plus_4      = $urandom;
      wb_wr_en       = $urandom_range(0, 1);
      wb_wr_addr     = AW'($urandom_range(0, 3));
      wb_wr_data     = $urandom_range(0, 3);
      mem_reg_wr_en  = $urandom_range(0, 1);
      mem_mem_to_reg = $urandom_range(0, 1);
      mem_wr_addr    = AW'($urandom_range(0, 3));
      mem_fwd_data   = $urandom_range(0, 3);
      flush_ex       = ($urandom_range(0, 9) == 0);
      ex_hold        = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
